odd_cnt_sched: RTL and testbench

ODD_CNT_SCHED -- requirements
Module: odd_cnt_sched

---
 rtl/odd_cnt_sched.sv | 243 ++++++++++++++++++++++++
 tb/tb_odd_cnt_sched.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/odd_cnt_sched.sv
// ---------------------------------------------------------------------------
// odd_cnt_sched
//
// Purpose:
//   Two requesters share one odd-number counter. A requester asks for a burst
//   of 1..16 consecutive odd values (a length of 0 encodes 16). The winner is
//   picked round-robin, receives a one-hot grant, and sees one odd value per
//   cycle with cnt_vld_o high. A single DONE cycle with done_o follows the
//   burst. If the granted requester withdraws its request during the burst,
//   the burst is aborted silently.
//
// Configuration macro:
//   ODD_CNT_SCHED_RESTART_EN
//     defined   : every burst starts at START_VAL (the counter reloads on grant)
//     undefined : the counter continues across bursts (the default)
//
// Parameters:
//   START_VAL  first odd value after reset (must be odd)
//
// Ports:
//   clk        sole clock, all state on the rising edge
//   reset      asynchronous active-low reset; release is synchronised to clk
//   req_i      per-requester burst request, bit n = requester n
//   len0_i     burst length of requester 0 (0 encodes 16)
//   len1_i     burst length of requester 1 (0 encodes 16)
//   gnt_o      one-hot grant of the counter
//   cnt_o      current odd counter value
//   cnt_vld_o  cnt_o is a valid burst element this cycle
//   done_o     one-cycle pulse at normal burst completion
//   busy_o     high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module odd_cnt_sched #(
  parameter logic [7:0] START_VAL = 8'd1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic [3:0] len0_i,
  input  logic [3:0] len1_i,
  output logic [1:0] gnt_o,
  output logic [7:0] cnt_o,
  output logic       cnt_vld_o,
  output logic       done_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Reset conditioning: assertion is immediate, release is delayed two clock
  // edges so that no flop leaves reset close to an active edge.
  // -------------------------------------------------------------------------
  logic [1:0] rst_sync_reg;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_reg <= 2'b00;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_reg[1];

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  state_t     state_reg,      state_next;
  logic [1:0] gnt_reg,        gnt_next;
  logic [7:0] cnt_reg,        cnt_next;
  logic       vld_reg,        vld_next;
  logic       done_reg,       done_next;
  logic       busy_reg,       busy_next;
  logic [4:0] remain_reg,     remain_next;
  logic       last_owner_reg, last_owner_next;

  // -------------------------------------------------------------------------
  // Length decode: a raw length of 0 stands for a 16-element burst.
  // -------------------------------------------------------------------------
  logic [1:0][3:0] len_raw;
  logic [1:0][4:0] len_dec;

  assign len_raw = {len1_i, len0_i};

  for (genvar gi = 0; gi < 2; gi++) begin : g_len
    assign len_dec[gi] = (len_raw[gi] == 4'd0) ? 5'd16 : {1'b0, len_raw[gi]};
  end

  // -------------------------------------------------------------------------
  // Round-robin arbitration. With both requesting, the requester that did
  // not own the last burst wins.
  // -------------------------------------------------------------------------
  logic       win_idx;
  logic [1:0] win_onehot;

  always_comb begin
    win_idx = 1'b0;
    case (req_i)
      2'b01:   win_idx = 1'b0;
      2'b10:   win_idx = 1'b1;
      2'b11:   win_idx = ~last_owner_reg;
      default: win_idx = 1'b0;
    endcase
  end

  assign win_onehot = win_idx ? 2'b10 : 2'b01;

  // The grant register is one-hot while a burst runs, so its upper bit is the
  // owner index.
  logic owner_idx;
  logic owner_req;

  assign owner_idx = gnt_reg[1];
  assign owner_req = req_i[owner_idx];

  // Odd step: adding 2 in 8 bits wraps 255 -> 1, so the value stays odd.
  logic [7:0] cnt_inc;
  logic [7:0] burst_start;

  assign cnt_inc = cnt_reg + 8'd2;

`ifdef ODD_CNT_SCHED_RESTART_EN
  assign burst_start = START_VAL;
`else
  assign burst_start = cnt_reg;
`endif

  // -------------------------------------------------------------------------
  // Process 1: state and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_reg      <= ST_IDLE;
      gnt_reg        <= 2'b00;
      cnt_reg        <= START_VAL;
      vld_reg        <= 1'b0;
      done_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      remain_reg     <= 5'd0;
      last_owner_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      gnt_reg        <= gnt_next;
      cnt_reg        <= cnt_next;
      vld_reg        <= vld_next;
      done_reg       <= done_next;
      busy_reg       <= busy_next;
      remain_reg     <= remain_next;
      last_owner_reg <= last_owner_next;
    end
  end

  // -------------------------------------------------------------------------
  // Process 2: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_i != 2'b00) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // A withdrawn request takes priority over normal completion.
        if (!owner_req) begin
          state_next = ST_IDLE;
        end else if (remain_reg == 5'd1) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Process 3: next values of the registered outputs and datapath
  // -------------------------------------------------------------------------
  always_comb begin
    gnt_next        = gnt_reg;
    cnt_next        = cnt_reg;
    vld_next        = 1'b0;
    done_next       = 1'b0;
    remain_next     = remain_reg;
    last_owner_next = last_owner_reg;
    busy_next       = (state_next != ST_IDLE);

    case (state_reg)
      ST_IDLE: begin
        gnt_next = 2'b00;
        if (req_i != 2'b00) begin
          // Length is captured only here; later length changes are ignored.
          gnt_next    = win_onehot;
          remain_next = len_dec[win_idx];
          cnt_next    = burst_start;
          vld_next    = 1'b1;
        end
      end

      ST_RUN: begin
        // The value shown this cycle had cnt_vld_o high, so it counts as
        // delivered whether the burst goes on, ends, or aborts. The counter
        // then holds the next odd value until the following burst.
        cnt_next = cnt_inc;
        if (!owner_req) begin
          gnt_next        = 2'b00;
          last_owner_next = owner_idx;
        end else if (remain_reg == 5'd1) begin
          done_next       = 1'b1;
          last_owner_next = owner_idx;
        end else begin
          vld_next    = 1'b1;
          remain_next = remain_reg - 5'd1;
        end
      end

      ST_DONE: begin
        gnt_next = 2'b00;
      end

      default: begin
        gnt_next = 2'b00;
      end
    endcase
  end

  assign gnt_o     = gnt_reg;
  assign cnt_o     = cnt_reg;
  assign cnt_vld_o = vld_reg;
  assign done_o    = done_reg;
  assign busy_o    = busy_reg;

endmodule

// File: tb/tb_odd_cnt_sched.sv
// ---------------------------------------------------------------------------
// tb_odd_cnt_sched
//
// Purpose:
//   Self-checking bench for odd_cnt_sched. A burst-level reference model
//   (round-robin owner, burst length, next odd value) predicts every cycle of
//   each burst; directed bursts are followed by randomised bursts with random
//   aborts and idle gaps, and mid-burst resets.
// ---------------------------------------------------------------------------
module tb_odd_cnt_sched;

  localparam logic [7:0] START_VAL = 8'd1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] req_i = 2'b00;
  logic [3:0] len0_i = 4'd0;
  logic [3:0] len1_i = 4'd0;
  logic [1:0] gnt_o;
  logic [7:0] cnt_o;
  logic       cnt_vld_o;
  logic       done_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;
  int burst_no = 0;

  // Reference model state
  int model_cnt  = START_VAL;  // next odd value to be delivered
  int last_owner = 1;

  odd_cnt_sched #(.START_VAL(START_VAL)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req_i),
    .len0_i    (len0_i),
    .len1_i    (len1_i),
    .gnt_o     (gnt_o),
    .cnt_o     (cnt_o),
    .cnt_vld_o (cnt_vld_o),
    .done_o    (done_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_winner(input logic [1:0] rq);
    if (rq == 2'b01) return 0;
    if (rq == 2'b10) return 1;
    return (last_owner == 0) ? 1 : 0;
  endfunction

  function automatic int dec_len(input logic [3:0] l);
    return (l == 4'd0) ? 16 : int'(l);
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_gnt"},  gnt_o, 2'b00);
    chk({tag, "_vld"},  cnt_vld_o, 1'b0);
    chk({tag, "_done"}, done_o, 1'b0);
    chk({tag, "_busy"}, busy_o, 1'b0);
    chk({tag, "_cnt"},  cnt_o, START_VAL);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_gnt"},  gnt_o, 2'b00);
    chk({tag, "_vld"},  cnt_vld_o, 1'b0);
    chk({tag, "_done"}, done_o, 1'b0);
    chk({tag, "_busy"}, busy_o, 1'b0);
    chk({tag, "_cnt"},  cnt_o, model_cnt);
  endtask

  // Release reset away from the clock edge and let the release ripple in.
  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_cnt  = START_VAL;
    last_owner = 1;
    check_idle("post_reset");
    $display("reset released cnt=%0d", cnt_o);
  endtask

  // Called at posedge+1: asserts reset mid-cycle and checks outputs at once.
  task automatic do_reset();
    req_i = 2'b00;
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("async_reset");
    release_reset();
  endtask

  // One burst request. abort_req: 0 = run to completion, n>0 = withdraw the
  // owner's request after n delivered values, <0 = let the bench choose.
  task automatic burst(input logic [1:0] rq, input logic [3:0] l0,
                       input logic [3:0] l1, input int abort_req);
    int w, n, ab, emit;
    logic [1:0] g;
    int first;
    w = pick_winner(rq);
    n = (w == 0) ? dec_len(l0) : dec_len(l1);
    if (abort_req < 0) begin
      ab = (n > 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, n - 1)) : 0;
    end else begin
      ab = abort_req;
    end
    emit = (ab > 0) ? ab : n;
    g = (w == 0) ? 2'b01 : 2'b10;
`ifdef ODD_CNT_SCHED_RESTART_EN
    model_cnt = START_VAL;
`endif
    first = model_cnt;
    req_i  = rq;
    len0_i = l0;
    len1_i = l1;
    @(posedge clk);
    #1;
    for (int i = 0; i < emit; i++) begin
      chk("run_gnt",  gnt_o, g);
      chk("run_vld",  cnt_vld_o, 1'b1);
      chk("run_cnt",  cnt_o, model_cnt);
      chk("run_odd",  cnt_o[0], 1'b1);
      chk("run_done", done_o, 1'b0);
      chk("run_busy", busy_o, 1'b1);
      model_cnt = (model_cnt + 2) % 256;
      // Inputs other than the owner's request bit must have no effect now.
      len0_i = 4'($urandom);
      len1_i = 4'($urandom);
      req_i[1 - w] = 1'($urandom);
      if (ab > 0 && i == ab - 1) req_i[w] = 1'b0;
      @(posedge clk);
      #1;
    end
    last_owner = w;
    if (ab == 0) begin
      chk("done_pulse", done_o, 1'b1);
      chk("done_vld",   cnt_vld_o, 1'b0);
      chk("done_gnt",   gnt_o, g);
      chk("done_busy",  busy_o, 1'b1);
      @(posedge clk);
      #1;
    end
    check_idle(ab == 0 ? "after_done" : "after_abort");
    burst_no++;
    $display("burst %0d req=%b owner=%0d len=%0d first=%0d emitted=%0d %s",
             burst_no, rq, w, n, first, emit, (ab == 0) ? "done" : "aborted");
  endtask

  task automatic idle_gap(input int cycles);
    req_i = 2'b00;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      check_idle("gap");
    end
  endtask

  initial begin
    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("por");
    release_reset();

    // Single requester, length 3: values 1,3,5 then done
    burst(2'b01, 4'd3, 4'd7, 0);

    // Both requesting from reset: grants alternate 01,10,01
    do_reset();
    burst(2'b11, 4'd2, 4'd2, 0);
    burst(2'b11, 4'd2, 4'd2, 0);
    burst(2'b11, 4'd2, 4'd2, 0);

    // Length 0 encodes 16
    burst(2'b01, 4'd0, 4'd5, 0);

    // Abort after 2 of 5 values, next burst resumes
    burst(2'b01, 4'd5, 4'd1, 2);
    burst(2'b01, 4'd4, 4'd3, 0);

    // Walk the counter to 253 and cross the wrap
    do_reset();
    for (int k = 0; k < 20 && model_cnt != 253; k++) begin
      int need;
      need = (model_cnt < 253) ? (253 - model_cnt) / 2 : 16;
      if (need > 16 || need < 1) need = 16;
      burst(2'b01, 4'(need), 4'd1, 0);
    end
    burst(2'b01, 4'd3, 4'd9, 0);

    // Randomised bursts
    for (int k = 0; k < 40; k++) begin
      idle_gap($urandom_range(0, 2));
      burst(2'($urandom_range(1, 3)), 4'($urandom), 4'($urandom), -1);
    end

    // Reset in the middle of a burst, then a fresh burst
    req_i  = 2'b10;
    len1_i = 4'd8;
`ifdef ODD_CNT_SCHED_RESTART_EN
    model_cnt = START_VAL;
`endif
    @(posedge clk);
    #1;
    chk("mid_first_vld", cnt_vld_o, 1'b1);
    chk("mid_first_cnt", cnt_o, model_cnt);
    model_cnt = (model_cnt + 2) % 256;
    @(posedge clk);
    #1;
    chk("mid_second_cnt", cnt_o, model_cnt);
    do_reset();
    burst(2'b10, 4'd3, 4'd3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
